adc_frame_rx: RTL and testbench

Parametrised successor to the single-channel LTC2385/2386/2387 receiver. It deserialises NCH ADC channels, each with LANES DDR data lanes and BITS-bit results, in one system clock domain. Upstream DDR input primitives deliver the rise and fall samples already aligned to clk. The block adds frame counting, frame-error detection, sign/zero extension and a valid/ready output with overrun flagging. It sits between the DDR capture stage and the sample FIFO.

---
 rtl/adc_frame_rx_pkg.sv | 33 +++
 rtl/adc_frame_rx_chan_shift.sv | 48 ++++
 rtl/adc_frame_rx.sv | 147 ++++++++++++++
 tb/tb_adc_frame_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_rx_pkg.sv
// rtl/adc_frame_rx_pkg.sv - shared types, helpers and parameter checks for adc_frame_rx
package adc_frame_rx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int pairs_per_frame(input int bits, input int lanes);
    return (bits + 2 * lanes - 1) / (2 * lanes);
  endfunction

  // Bits at or above out_w are always zero so the caller can simply truncate.
  function automatic logic [31:0] extend(input logic [31:0] word, input int bits,
                                         input int out_w, input logic sgn);
    logic [31:0] res;
    logic        msb;
    msb = word[bits-1];
    for (int i = 0; i < 32; i++) begin
      if (i < bits)       res[i] = word[i];
      else if (i < out_w) res[i] = sgn & msb;
      else                res[i] = 1'b0;
    end
    return res;
  endfunction

  function automatic bit params_ok(input int nch, input int lanes, input int bits,
                                   input int out_w);
    return (nch >= 1) && (nch <= 8) && ((lanes == 1) || (lanes == 2) || (lanes == 4)) &&
           (bits >= 12) && (bits <= 24) && (out_w >= bits) && (out_w <= 32);
  endfunction

endpackage

// File: rtl/adc_frame_rx_chan_shift.sv
// rtl/adc_frame_rx_chan_shift.sv - per-channel DDR pair shift register, reorder and truncation
module adc_chan_shift
  import adc_frame_rx_pkg::*;
#(
  parameter int LANES = 1,
  parameter int BITS  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic [LANES-1:0] i_rise,
  input  logic [LANES-1:0] i_fall,
  output logic [BITS-1:0]  o_result
);

  localparam int P  = pairs_per_frame(BITS, LANES);
  localparam int PW = 2 * LANES;
  localparam int FW = PW * P;

  // Only the older P-1 pairs are stored; the newest pair joins combinationally
  // so the complete frame is visible in the same cycle as its last pair.
  logic [FW-PW-1:0] r_hist;
  logic [PW-1:0]    w_pair;
  logic [FW-1:0]    w_frame;

  always_comb begin
    w_pair = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pair[PW-1-l]    = i_rise[l];
      w_pair[LANES-1-l] = i_fall[l];
    end
  end

  assign w_frame  = {r_hist, w_pair};
  assign o_result = w_frame[FW-1 -: BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist <= w_frame[FW-PW-1:0];
    end
  end

endmodule

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - multi-channel DDR ADC frame receiver with valid/ready output
module adc_frame_rx
  import adc_frame_rx_pkg::*;
#(
  parameter int NCH   = 1,
  parameter int LANES = 1,
  parameter int BITS  = 18,
  parameter int OUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pair_valid,
  input  logic [NCH*LANES-1:0] d_rise,
  input  logic [NCH*LANES-1:0] d_fall,
  input  logic                 twos_comp,
  input  logic                 clr_flags,
  output logic [NCH*OUT_W-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overrun,
  output logic                 short_err
);

  localparam int P  = pairs_per_frame(BITS, LANES);
  localparam int CW = $clog2(P);

  if (!params_ok(NCH, LANES, BITS, OUT_W)) begin : g_param_check
    $error("adc_frame_rx: parameter out of range");
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nx;
  logic             w_shift;
  logic             w_clear;
  logic             w_capture;
  logic             w_short_set;
  logic             w_ov_set;
  logic [BITS-1:0]  w_result [NCH];
  logic [NCH*OUT_W-1:0] w_ext;
  logic [NCH*OUT_W-1:0] r_dout;
  logic             r_valid;
  logic             r_overrun;
  logic             r_short;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
    end
  end

  // A pair arriving with frame_start still belongs to the running frame;
  // the re-arm is applied after it, so a completing pair is never a short frame.
  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_short_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_state_nx = ST_SHIFT;
          w_count_nx = '0;
          w_clear    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (pair_valid) begin
          w_shift = 1'b1;
          if (r_count == CW'(P - 1)) begin
            w_capture  = 1'b1;
            w_state_nx = ST_IDLE;
            w_count_nx = '0;
          end else begin
            w_count_nx = r_count + 1'b1;
          end
        end
        if (frame_start) begin
          w_short_set = ~w_capture;
          w_state_nx  = ST_SHIFT;
          w_count_nx  = '0;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_count_nx = '0;
      end
    endcase
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    adc_chan_shift #(
      .LANES(LANES),
      .BITS (BITS)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_shift (w_shift),
      .i_rise  (d_rise[ch*LANES +: LANES]),
      .i_fall  (d_fall[ch*LANES +: LANES]),
      .o_result(w_result[ch])
    );
  end

  always_comb begin
    w_ext = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      w_ext[ch*OUT_W +: OUT_W] = OUT_W'(extend(32'(w_result[ch]), BITS, OUT_W, twos_comp));
    end
  end

  assign w_ov_set = w_capture & r_valid & ~dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_short   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dout  <= w_ext;
        r_valid <= 1'b1;
      end else if (r_valid && dout_ready) begin
        r_valid <= 1'b0;
      end
      r_overrun <= w_ov_set | (r_overrun & ~clr_flags);
      r_short   <= w_short_set | (r_short & ~clr_flags);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_overrun;
  assign short_err  = r_short;

endmodule

// File: tb/tb_adc_frame_rx.sv
// tb/tb_adc_frame_rx.sv - self-checking bench for adc_frame_rx over three parameter sets
module tb_adc_frame_rx;

  logic        clk, rst, frame_start, pair_valid, twos_comp, clr_flags, dout_ready;
  logic [5:0]  rise_v, fall_v;
  logic [23:0] dout_a, dout_c;
  logic [47:0] dout_b;
  logic        valid_a, valid_b, valid_c, ov_a, ov_b, ov_c, sh_a, sh_b, sh_c;

  int total = 0;
  int bad   = 0;

  // Instance index: 0 = A (1ch, 1 lane, 18b), 1 = B (2ch, 2 lanes, 18b), 2 = C (1ch, 1 lane, 16b)
  int    cfg_n   [3] = '{1, 2, 1};
  int    cfg_l   [3] = '{1, 2, 1};
  int    cfg_b   [3] = '{18, 18, 16};
  int    cfg_off [3] = '{0, 2, 1};
  string nm      [3] = '{"a", "b", "c"};

  bit          m_armed [3];
  int          m_pairs [3];
  longint      m_acc   [3][2];
  logic        m_valid [3], m_ov [3], m_sh [3];
  logic [47:0] m_dout  [3];

  typedef struct {
    logic        tc;
    logic [17:0] a;
    logic [15:0] c;
    logic [17:0] b0, b1;
    logic [23:0] ea, ec, eb0, eb1;
  } vec_t;
  vec_t tbl [4];

  adc_frame_rx #(.NCH(1), .LANES(1), .BITS(18), .OUT_W(24)) u_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pair_valid(pair_valid),
    .d_rise(rise_v[0:0]), .d_fall(fall_v[0:0]), .twos_comp(twos_comp), .clr_flags(clr_flags),
    .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready), .overrun(ov_a), .short_err(sh_a));

  adc_frame_rx #(.NCH(2), .LANES(2), .BITS(18), .OUT_W(24)) u_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pair_valid(pair_valid),
    .d_rise(rise_v[5:2]), .d_fall(fall_v[5:2]), .twos_comp(twos_comp), .clr_flags(clr_flags),
    .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready), .overrun(ov_b), .short_err(sh_b));

  adc_frame_rx #(.NCH(1), .LANES(1), .BITS(16), .OUT_W(24)) u_c (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pair_valid(pair_valid),
    .d_rise(rise_v[1:1]), .d_fall(fall_v[1:1]), .twos_comp(twos_comp), .clr_flags(clr_flags),
    .dout(dout_c), .dout_valid(valid_c), .dout_ready(dout_ready), .overrun(ov_c), .short_err(sh_c));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mext(input longint v, input int bits, input logic tc);
    longint x;
    x = v;
    if (tc && (((v >> (bits - 1)) & 1) == 1)) x = v - (longint'(1) << bits);
    return 24'(x);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_armed[k] = 0; m_pairs[k] = 0; m_acc[k][0] = 0; m_acc[k][1] = 0;
      m_valid[k] = 0; m_ov[k] = 0; m_sh[k] = 0; m_dout[k] = '0;
    end
  endtask

  // Stream-level model: bits are appended MSB-first and the frame is read off arithmetically.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int L, P, off;
      bit cap, sh, ov;
      L = cfg_l[k]; P = (cfg_b[k] + 2 * L - 1) / (2 * L); off = cfg_off[k];
      cap = 0; sh = 0; ov = 0;
      if (m_armed[k] && pair_valid) begin
        for (int ch = 0; ch < cfg_n[k]; ch++) begin
          for (int l = 0; l < L; l++) m_acc[k][ch] = m_acc[k][ch] * 2 + longint'(rise_v[off + ch * L + l]);
          for (int l = 0; l < L; l++) m_acc[k][ch] = m_acc[k][ch] * 2 + longint'(fall_v[off + ch * L + l]);
        end
        m_pairs[k]++;
        if (m_pairs[k] == P) begin
          cap = 1;
          m_armed[k] = 0;
        end
      end
      if (cap) begin
        for (int ch = 0; ch < cfg_n[k]; ch++) begin
          longint v;
          v = (m_acc[k][ch] >> (2 * L * P - cfg_b[k])) & ((longint'(1) << cfg_b[k]) - 1);
          m_dout[k][ch*24 +: 24] = mext(v, cfg_b[k], twos_comp);
        end
        ov = m_valid[k] && !dout_ready;
        m_valid[k] = 1;
      end else if (m_valid[k] && dout_ready) begin
        m_valid[k] = 0;
      end
      if (frame_start) begin
        sh = m_armed[k];
        m_armed[k] = 1; m_pairs[k] = 0; m_acc[k][0] = 0; m_acc[k][1] = 0;
      end
      m_ov[k] = ov | (m_ov[k] & !clr_flags);
      m_sh[k] = sh | (m_sh[k] & !clr_flags);
    end
  endtask

  task automatic check_all();
    logic [47:0] ad [3];
    logic        av [3], ao [3], as [3];
    ad[0] = {24'h0, dout_a}; ad[1] = dout_b; ad[2] = {24'h0, dout_c};
    av[0] = valid_a; av[1] = valid_b; av[2] = valid_c;
    ao[0] = ov_a;    ao[1] = ov_b;    ao[2] = ov_c;
    as[0] = sh_a;    as[1] = sh_b;    as[2] = sh_c;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_dout", nm[k]), 64'(ad[k]), 64'(m_dout[k]));
      chk($sformatf("%s_valid", nm[k]), 64'(av[k]), 64'(m_valid[k]));
      chk($sformatf("%s_overrun", nm[k]), 64'(ao[k]), 64'(m_ov[k]));
      chk($sformatf("%s_short_err", nm[k]), 64'(as[k]), 64'(m_sh[k]));
    end
  endtask

  task automatic step();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic set_pair(input logic [17:0] a, input logic [15:0] c, input logic [17:0] b0,
                          input logic [17:0] b1, input int p);
    logic [17:0] bw;
    int s;
    rise_v = 6'($urandom);
    fall_v = 6'($urandom);
    if (p < 9) begin rise_v[0] = a[17 - 2 * p]; fall_v[0] = a[16 - 2 * p]; end
    if (p < 8) begin rise_v[1] = c[15 - 2 * p]; fall_v[1] = c[14 - 2 * p]; end
    if (p < 5) begin
      for (int ch = 0; ch < 2; ch++) begin
        bw = (ch == 1) ? b1 : b0;
        for (int l = 0; l < 2; l++) begin
          s = 19 - 4 * p - l;
          if (s >= 2) rise_v[2 + ch * 2 + l] = bw[s - 2];
          s = 17 - 4 * p - l;
          if (s >= 2) fall_v[2 + ch * 2 + l] = bw[s - 2];
        end
      end
    end
  endtask

  task automatic send_frame(input logic [17:0] a, input logic [15:0] c, input logic [17:0] b0,
                            input logic [17:0] b1, input bit arm, input int np, input bit fs_last);
    if (arm) begin
      frame_start = 1; pair_valid = 0;
      step();
    end
    for (int p = 0; p < np; p++) begin
      set_pair(a, c, b0, b1, p);
      frame_start = fs_last && (p == np - 1);
      pair_valid  = 1;
      step();
    end
    frame_start = 0;
    pair_valid  = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 18'h2A5A5, 16'hBEEF, 18'h20001, 18'h1FFFF, 24'h02A5A5, 24'h00BEEF, 24'h020001, 24'h01FFFF};
    tbl[1] = '{1'b1, 18'h2A5A5, 16'hBEEF, 18'h20001, 18'h1FFFF, 24'hFEA5A5, 24'hFFBEEF, 24'hFE0001, 24'h01FFFF};
    tbl[2] = '{1'b1, 18'h1FFFF, 16'h7FFF, 18'h3FFFF, 18'h00000, 24'h01FFFF, 24'h007FFF, 24'hFFFFFF, 24'h000000};
    tbl[3] = '{1'b0, 18'h3FFFF, 16'h8000, 18'h12345, 18'h2ABCD, 24'h03FFFF, 24'h008000, 24'h012345, 24'h02ABCD};

    clk = 0; rst = 1; frame_start = 0; pair_valid = 0; twos_comp = 0;
    clr_flags = 0; dout_ready = 1; rise_v = '0; fall_v = '0;
    model_reset();
    step();
    step();
    chk("reset_dout_b", 64'(dout_b), 64'd0);
    chk("reset_valid_a", 64'(valid_a), 64'd0);
    chk("reset_flags_c", 64'({ov_c, sh_c}), 64'd0);
    rst = 0;
    step();

    for (int i = 0; i < 4; i++) begin
      twos_comp = tbl[i].tc;
      send_frame(tbl[i].a, tbl[i].c, tbl[i].b0, tbl[i].b1, 1, 9, 0);
      chk($sformatf("tbl%0d_a", i), 64'(dout_a), 64'(tbl[i].ea));
      chk($sformatf("tbl%0d_a_valid", i), 64'(valid_a), 64'd1);
      chk($sformatf("tbl%0d_c", i), 64'(dout_c), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d_b0", i), 64'(dout_b[23:0]), 64'(tbl[i].eb0));
      chk($sformatf("tbl%0d_b1", i), 64'(dout_b[47:24]), 64'(tbl[i].eb1));
    end

    twos_comp = 0;
    send_frame(18'h0, 16'h1111, 18'h0, 18'h0, 1, 4, 0);
    frame_start = 1;
    step();
    frame_start = 0;
    chk("short_c_err", 64'(sh_c), 64'd1);
    chk("short_c_novalid", 64'(valid_c), 64'd0);
    send_frame(18'h0, 16'hBEEF, 18'h0, 18'h0, 0, 9, 0);
    chk("short_next_c", 64'(dout_c), 64'h00BEEF);
    clr_flags = 1; step(); clr_flags = 0;
    chk("short_clr_c", 64'(sh_c), 64'd0);

    dout_ready = 0;
    send_frame(18'h1234, 16'h1234, 18'h1234, 18'h1234, 1, 9, 0);
    send_frame(18'h5678, 16'h5678, 18'h5678, 18'h5678, 1, 9, 0);
    chk("ovr_c_flag", 64'(ov_c), 64'd1);
    chk("ovr_c_dout", 64'(dout_c), 64'h005678);
    clr_flags = 1; step(); clr_flags = 0;
    chk("ovr_clr_c", 64'(ov_c), 64'd0);
    dout_ready = 1;
    step();

    send_frame(18'h0, 16'hA5A5, 18'h0, 18'h0, 1, 8, 1);
    chk("coin_c_valid", 64'(valid_c), 64'd1);
    chk("coin_c_short", 64'(sh_c), 64'd0);
    chk("coin_c_dout", 64'(dout_c), 64'h00A5A5);
    send_frame(18'h0, 16'h4321, 18'h0, 18'h0, 0, 8, 0);
    chk("coin_next_c_valid", 64'(valid_c), 64'd1);
    chk("coin_next_c_dout", 64'(dout_c), 64'h004321);

    dout_ready = 0;
    send_frame(18'h0F0F, 16'h0F0F, 18'h0F0F, 18'h0F0F, 1, 9, 0);
    send_frame(18'h1, 16'h1, 18'h1, 18'h1, 1, 3, 0);
    rst = 1;
    #1;
    chk("rst_async_a", 64'({dout_a, valid_a, ov_a, sh_a}), 64'd0);
    chk("rst_async_b", 64'({dout_b, valid_b, ov_b, sh_b}), 64'd0);
    chk("rst_async_c", 64'({dout_c, valid_c, ov_c, sh_c}), 64'd0);
    model_reset();
    step();
    rst = 0;
    dout_ready = 1;
    twos_comp = tbl[1].tc;
    send_frame(tbl[1].a, tbl[1].c, tbl[1].b0, tbl[1].b1, 1, 9, 0);
    chk("post_rst_a", 64'(dout_a), 64'(tbl[1].ea));
    chk("post_rst_b", 64'(dout_b), 64'({tbl[1].eb1, tbl[1].eb0}));

    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      frame_start = ($urandom_range(0, 9) == 0);
      pair_valid  = ($urandom_range(0, 3) != 0);
      rise_v      = 6'($urandom);
      fall_v      = 6'($urandom);
      twos_comp   = 1'($urandom);
      dout_ready  = ($urandom_range(0, 2) != 0);
      clr_flags   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
